// File: rtl/id_stage_pipe_if.sv
// Fetch-side and EX-side handshake/bus bundle of the registered RV32I decode stage.
// Optional ID_ILLEGAL_TRAP_EN adds the registered illegal_o flag.
interface id_stage_pipe_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CSR_AW = 12
);
   logic              if_valid_i;
   logic              if_ready_o;
   logic [31:0]       inst_i;
   logic [XLEN-1:0]   inst_addr_i;
   logic              ex_valid_o;
   logic              ex_ready_i;
   logic [XLEN-1:0]   op1_o;
   logic [XLEN-1:0]   op2_o;
   logic [XLEN-1:0]   offset_o;
   logic [31:0]       inst_o;
   logic [XLEN-1:0]   inst_addr_o;
   logic              reg_wen_o;
   logic [REG_AW-1:0] reg_waddr_o;
   logic              csr_wen_o;
   logic [CSR_AW-1:0] csr_addr_o;
   logic              is_load_o;
`ifdef ID_ILLEGAL_TRAP_EN
   logic              illegal_o;
`endif

   // Decode stage view.
   modport slave (
      input  if_valid_i, inst_i, inst_addr_i, ex_ready_i,
      output if_ready_o, ex_valid_o, op1_o, op2_o, offset_o, inst_o, inst_addr_o,
             reg_wen_o, reg_waddr_o, csr_wen_o, csr_addr_o, is_load_o
`ifdef ID_ILLEGAL_TRAP_EN
      , illegal_o
`endif
   );

   // Fetch/EX environment view.
   modport master (
      output if_valid_i, inst_i, inst_addr_i, ex_ready_i,
      input  if_ready_o, ex_valid_o, op1_o, op2_o, offset_o, inst_o, inst_addr_o,
             reg_wen_o, reg_waddr_o, csr_wen_o, csr_addr_o, is_load_o
`ifdef ID_ILLEGAL_TRAP_EN
      , illegal_o
`endif
   );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: valid/ready on both sides, ID/EX register, load-use stall, flush.
// Optional ID_ILLEGAL_TRAP_EN exports a registered illegal-instruction flag.
module id_stage_pipe #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CSR_AW = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   id_stage_pipe_if.slave    bus,
   output logic [REG_AW-1:0] reg1_raddr_o,
   output logic [REG_AW-1:0] reg2_raddr_o,
   input  logic [XLEN-1:0]   reg1_rdata_i,
   input  logic [XLEN-1:0]   reg2_rdata_i
);
   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_FENCE  = 7'b0001111,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_R      = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } opcode_e;

   typedef struct packed {
`ifdef ID_ILLEGAL_TRAP_EN
      logic              illegal;
`endif
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [XLEN-1:0]   offset;
      logic              reg_wen;
      logic [REG_AW-1:0] reg_waddr;
      logic              csr_wen;
      logic [CSR_AW-1:0] csr_addr;
      logic              is_load;
   } dec_t;

   logic [2:0]        w_f3;
   logic [6:0]        w_f7;
   logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
   logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
   logic              w_load_f3_ok, w_store_f3_ok;
   logic              w_rs1_use, w_rs2_use, w_illegal;
   logic              w_adv, w_hazard, w_xfer;
   dec_t              w_dec;

   logic              r_ex_valid;
   dec_t              r_dec;
   logic [31:0]       r_inst;
   logic [XLEN-1:0]   r_pc;

   assign w_f3    = bus.inst_i[14:12];
   assign w_f7    = bus.inst_i[31:25];
   assign w_rs1   = REG_AW'(bus.inst_i[19:15]);
   assign w_rs2   = REG_AW'(bus.inst_i[24:20]);
   assign w_rd    = REG_AW'(bus.inst_i[11:7]);
   assign w_imm_i = XLEN'($signed(bus.inst_i[31:20]));
   assign w_imm_s = XLEN'($signed({bus.inst_i[31:25], bus.inst_i[11:7]}));
   assign w_imm_b = XLEN'($signed({bus.inst_i[31], bus.inst_i[7], bus.inst_i[30:25],
                                   bus.inst_i[11:8], 1'b0}));
   assign w_imm_j = XLEN'($signed({bus.inst_i[31], bus.inst_i[19:12], bus.inst_i[20],
                                   bus.inst_i[30:21], 1'b0}));
   assign w_imm_u = XLEN'($signed({bus.inst_i[31:12], 12'b0}));

   // LD/LWU/SD only exist on the 64-bit datapath.
   assign w_load_f3_ok  = (w_f3 != 3'b111) &&
                          ((XLEN == 64) || (w_f3 != 3'b011 && w_f3 != 3'b110));
   assign w_store_f3_ok = !w_f3[2] && ((XLEN == 64) || (w_f3 != 3'b011));

   always_comb begin
      // NOTE: every combinational output is defaulted first so no decode path can infer a latch.
      w_dec     = '0;
      w_rs1_use = 1'b0;
      w_rs2_use = 1'b0;
      w_illegal = 1'b0;
      case (bus.inst_i[6:0])
         OP_R: begin
            w_dec.op1     = reg1_rdata_i;
            w_dec.op2     = reg2_rdata_i;
            w_dec.reg_wen = 1'b1;
            w_rs1_use     = 1'b1;
            w_rs2_use     = 1'b1;
            w_illegal     = (w_f7 != 7'h00) &&
                            !(w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101));
         end
         OP_IMM, OP_LOAD: begin
            w_dec.op1     = reg1_rdata_i;
            w_dec.op2     = w_imm_i;
            w_dec.reg_wen = 1'b1;
            w_dec.is_load = (bus.inst_i[6:0] == OP_LOAD);
            w_rs1_use     = 1'b1;
            w_illegal     = (bus.inst_i[6:0] == OP_LOAD) && !w_load_f3_ok;
         end
         OP_STORE, OP_BRANCH: begin
            w_dec.op1    = reg1_rdata_i;
            w_dec.op2    = reg2_rdata_i;
            w_dec.offset = (bus.inst_i[6:0] == OP_STORE) ? w_imm_s : w_imm_b;
            w_rs1_use    = 1'b1;
            w_rs2_use    = 1'b1;
            w_illegal    = (bus.inst_i[6:0] == OP_STORE) ? !w_store_f3_ok
                                                         : (w_f3[2:1] == 2'b01);
         end
         OP_JAL: begin
            w_dec.op1     = bus.inst_addr_i;
            w_dec.op2     = XLEN'(4);
            w_dec.offset  = w_imm_j;
            w_dec.reg_wen = 1'b1;
         end
         OP_JALR: begin
            w_dec.op1     = reg1_rdata_i;
            w_dec.op2     = bus.inst_addr_i;
            w_dec.offset  = w_imm_i;
            w_dec.reg_wen = 1'b1;
            w_rs1_use     = 1'b1;
            w_illegal     = (w_f3 != 3'b000);
         end
         OP_LUI, OP_AUIPC: begin
            w_dec.op1     = w_imm_u;
            w_dec.op2     = (bus.inst_i[6:0] == OP_AUIPC) ? bus.inst_addr_i : '0;
            w_dec.reg_wen = 1'b1;
         end
         OP_FENCE: begin
         end
         OP_SYSTEM: begin
            if (w_f3[1:0] != 2'b00) begin
               // Set/clear with a zero source must not write the CSR.
               w_dec.op1      = w_f3[2] ? XLEN'(bus.inst_i[19:15]) : reg1_rdata_i;
               w_dec.reg_wen  = 1'b1;
               w_dec.csr_wen  = !(w_f3[1] && bus.inst_i[19:15] == 5'd0);
               w_dec.csr_addr = CSR_AW'(bus.inst_i[31:20]);
               w_rs1_use      = !w_f3[2];
            end else begin
               w_illegal = w_f3[2];
            end
         end
         default: w_illegal = 1'b1;
      endcase
      w_dec.reg_waddr = w_dec.reg_wen ? w_rd : '0;
      w_dec.reg_wen   = w_dec.reg_wen && (w_rd != '0);
      if (w_illegal) begin
         w_dec     = '0;
         w_rs1_use = 1'b0;
         w_rs2_use = 1'b0;
      end
`ifdef ID_ILLEGAL_TRAP_EN
      w_dec.illegal = w_illegal;
`endif
   end

   assign reg1_raddr_o = w_rs1_use ? w_rs1 : '0;
   assign reg2_raddr_o = w_rs2_use ? w_rs2 : '0;

   assign w_adv    = !r_ex_valid || bus.ex_ready_i;
   assign w_hazard = bus.if_valid_i && r_ex_valid && r_dec.is_load && (r_dec.reg_waddr != '0) &&
                     ((w_rs1_use && w_rs1 == r_dec.reg_waddr) ||
                      (w_rs2_use && w_rs2 == r_dec.reg_waddr));
   assign bus.if_ready_o = w_adv && !w_hazard && !flush_i;
   assign w_xfer         = bus.if_valid_i && bus.if_ready_o;

   // NOTE: pipeline state is written with non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_ex_valid <= 1'b0;
         r_dec      <= '0;
         r_inst     <= '0;
         r_pc       <= '0;
      end else if (w_adv) begin
         r_ex_valid <= w_xfer;
         r_dec      <= w_xfer ? w_dec          : '0;
         r_inst     <= w_xfer ? bus.inst_i      : '0;
         r_pc       <= w_xfer ? bus.inst_addr_i : '0;
      end
   end

   assign bus.ex_valid_o  = r_ex_valid;
   assign bus.op1_o       = r_dec.op1;
   assign bus.op2_o       = r_dec.op2;
   assign bus.offset_o    = r_dec.offset;
   assign bus.inst_o      = r_inst;
   assign bus.inst_addr_o = r_pc;
   assign bus.reg_wen_o   = r_dec.reg_wen;
   assign bus.reg_waddr_o = r_dec.reg_waddr;
   assign bus.csr_wen_o   = r_dec.csr_wen;
   assign bus.csr_addr_o  = r_dec.csr_addr;
   assign bus.is_load_o   = r_dec.is_load;
`ifdef ID_ILLEGAL_TRAP_EN
   assign bus.illegal_o   = r_dec.illegal;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (32-bit instance plus a 64-bit instance for sign extension).
module tb_id_stage_pipe;
   logic clk = 1'b0;
   logic rst;
   logic flush;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   id_stage_pipe_if #(.XLEN(32)) bus ();
   logic [4:0]  r1a, r2a;
   logic [31:0] r1d, r2d;
   assign r1d = 32'hA000_0000 | {27'd0, r1a};
   assign r2d = 32'hB000_0000 | {27'd0, r2a};

   id_stage_pipe #(.XLEN(32), .REG_AW(5), .CSR_AW(12)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus),
      .reg1_raddr_o(r1a), .reg2_raddr_o(r2a), .reg1_rdata_i(r1d), .reg2_rdata_i(r2d)
   );

   id_stage_pipe_if #(.XLEN(64)) bus64 ();
   logic [4:0]  r1a64, r2a64;
   logic [63:0] r1d64, r2d64;
   assign r1d64 = {59'd0, r1a64};
   assign r2d64 = {59'd0, r2a64};

   id_stage_pipe #(.XLEN(64), .REG_AW(5), .CSR_AW(12)) dut64 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus64),
      .reg1_raddr_o(r1a64), .reg2_raddr_o(r2a64), .reg1_rdata_i(r1d64), .reg2_rdata_i(r2d64)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
      bus.if_valid_i  = 1'b1;
      bus.inst_i      = inst;
      bus.inst_addr_i = pc;
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      bus.if_valid_i    = 1'b0;
      bus.inst_i        = '0;
      bus.inst_addr_i   = '0;
      bus.ex_ready_i    = 1'b1;
      bus64.if_valid_i  = 1'b0;
      bus64.inst_i      = '0;
      bus64.inst_addr_i = '0;
      bus64.ex_ready_i  = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_valid", bus.ex_valid_o, 0);
      check("rst_op1",   bus.op1_o, 0);
      check("rst_wen",   bus.reg_wen_o, 0);
      check("rst_inst",  bus.inst_o, 0);
      check("rst_ready", bus.if_ready_o, 1);

      // addi x1,x0,5
      offer(32'h0050_0093, 32'h0);
      check("addi_raddr1", r1a, 0);
      step();
      check("addi_valid", bus.ex_valid_o, 1);
      check("addi_op1",   bus.op1_o, 32'hA000_0000);
      check("addi_op2",   bus.op2_o, 5);
      check("addi_waddr", bus.reg_waddr_o, 1);
      check("addi_wen",   bus.reg_wen_o, 1);
`ifdef ID_ILLEGAL_TRAP_EN
      check("addi_illegal", bus.illegal_o, 0);
`endif

      // lw x2,0(x1) then add x3,x2,x2: one bubble
      offer(32'h0000_A103, 32'h4);
      step();
      check("lw_load",  bus.is_load_o, 1);
      check("lw_waddr", bus.reg_waddr_o, 2);
      check("lw_op1",   bus.op1_o, 32'hA000_0001);
      offer(32'h0021_01B3, 32'h8);
      check("hz_ready", bus.if_ready_o, 0);
      step();
      check("hz_bubble", bus.ex_valid_o, 0);
      check("hz_ready2", bus.if_ready_o, 1);
      step();
      check("add_valid", bus.ex_valid_o, 1);
      check("add_pc",    bus.inst_addr_o, 32'h8);
      check("add_op1",   bus.op1_o, 32'hA000_0002);
      check("add_op2",   bus.op2_o, 32'hB000_0002);
      check("add_load",  bus.is_load_o, 0);

      // EX back-pressure for 3 cycles with addi x4,x0,7 pending
      bus.ex_ready_i = 1'b0;
      offer(32'h0070_0213, 32'hC);
      for (int i = 0; i < 3; i++) begin
         check("hold_ready", bus.if_ready_o, 0);
         step();
         check("hold_valid", bus.ex_valid_o, 1);
         check("hold_pc",    bus.inst_addr_o, 32'h8);
         check("hold_op1",   bus.op1_o, 32'hA000_0002);
      end
      bus.ex_ready_i = 1'b1;
      #1;
      check("rel_ready", bus.if_ready_o, 1);
      step();
      check("rel_pc",    bus.inst_addr_o, 32'hC);
      check("rel_op2",   bus.op2_o, 7);
      check("rel_waddr", bus.reg_waddr_o, 4);

      // beq x1,x2,+8, then flush while held
      offer(32'h0020_8463, 32'h10);
      step();
      check("beq_off", bus.offset_o, 8);
      check("beq_wen", bus.reg_wen_o, 0);
      check("beq_op2", bus.op2_o, 32'hB000_0002);
      bus.ex_ready_i = 1'b0;
      flush = 1'b1;
      offer(32'hFFDF_F0EF, 32'h100);
      check("fl_ready", bus.if_ready_o, 0);
      step();
      flush = 1'b0;
      check("fl_valid", bus.ex_valid_o, 0);
      check("fl_pc",    bus.inst_addr_o, 0);

      // jal x1,-4 at 0x100 (rs1 field non-zero but unused)
      bus.ex_ready_i = 1'b1;
      #1;
      check("jal_raddr1", r1a, 0);
      step();
      check("jal_valid", bus.ex_valid_o, 1);
      check("jal_op1",   bus.op1_o, 32'h100);
      check("jal_op2",   bus.op2_o, 4);
      check("jal_off",   bus.offset_o, 32'hFFFF_FFFC);
      check("jal_wen",   bus.reg_wen_o, 1);

      // addi x0,x0,1
      offer(32'h0010_0013, 32'h104);
      step();
      check("x0_valid", bus.ex_valid_o, 1);
      check("x0_wen",   bus.reg_wen_o, 0);

      // sw x2,8(x1)
      offer(32'h0020_A423, 32'h108);
      check("sw_raddr1", r1a, 1);
      check("sw_raddr2", r2a, 2);
      step();
      check("sw_op2", bus.op2_o, 32'hB000_0002);
      check("sw_off", bus.offset_o, 8);
      check("sw_wen", bus.reg_wen_o, 0);

      // csrrs x5,0x300,x0 -> no CSR write
      offer(32'h3000_22F3, 32'h10C);
      step();
      check("csrrs_cwen", bus.csr_wen_o, 0);
      check("csrrs_wen",  bus.reg_wen_o, 1);
      check("csrrs_addr", bus.csr_addr_o, 12'h300);
      check("csrrs_wa",   bus.reg_waddr_o, 5);

      // csrrw x5,0x300,x1
      offer(32'h3000_92F3, 32'h110);
      step();
      check("csrrw_cwen", bus.csr_wen_o, 1);
      check("csrrw_op1",  bus.op1_o, 32'hA000_0001);

      // unknown opcode 0x7F with rd=1
      offer(32'h0000_00FF, 32'h114);
      step();
      check("unk_valid", bus.ex_valid_o, 1);
      check("unk_wen",   bus.reg_wen_o, 0);
      check("unk_op1",   bus.op1_o, 0);
      check("unk_inst",  bus.inst_o, 32'h0000_00FF);
`ifdef ID_ILLEGAL_TRAP_EN
      check("unk_illegal", bus.illegal_o, 1);
`endif

      // R-type with func7=0x01 is not a base-ISA instruction
      offer(32'h0221_01B3, 32'h118);
      step();
      check("f7_wen", bus.reg_wen_o, 0);
      check("f7_op1", bus.op1_o, 0);

      // lui x5,0x80000 on both widths
      offer(32'h8000_02B7, 32'h11C);
      bus64.if_valid_i  = 1'b1;
      bus64.inst_i      = 32'h8000_02B7;
      bus64.inst_addr_i = 64'h11C;
      step();
      bus64.if_valid_i = 1'b0;
      check("lui32_op1",   bus.op1_o, 32'h8000_0000);
      check("lui64_valid", bus64.ex_valid_o, 1);
      check("lui64_op1",   bus64.op1_o, 64'hFFFF_FFFF_8000_0000);
      check("lui64_wen",   bus64.reg_wen_o, 1);

      // reset and flush together
      bus.if_valid_i = 1'b0;
      rst   = 1'b1;
      flush = 1'b1;
      step();
      rst   = 1'b0;
      flush = 1'b0;
      check("rf_valid", bus.ex_valid_o, 0);
      check("rf_op1",   bus.op1_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered RV32I decode stage. Successor to the combinational decoder.
- Adds a valid/ready handshake on both sides, an ID/EX pipeline register, load-use hazard stall with bubble insertion, and flush.
- Sits between the fetch unit and EX. Reads gp_regs through combinational read ports.
- Generalised in data width (XLEN) and register count.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN
REG_AW, 5, register address width
CSR_AW, 12, CSR address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  kill in-flight and incoming instruction
if_valid_i  in  1  fetch offers instruction
if_ready_o  out  1  stage accepts instruction (combinational)
inst_i  in  32  instruction
inst_addr_i  in  XLEN  instruction PC
reg1_raddr_o  out  REG_AW  rs1 read address (combinational)
reg2_raddr_o  out  REG_AW  rs2 read address (combinational)
reg1_rdata_i  in  XLEN  rs1 data
reg2_rdata_i  in  XLEN  rs2 data
ex_valid_o  out  1  output register holds an instruction
ex_ready_i  in  1  EX accepts
op1_o, op2_o, offset_o  out  XLEN  operands
inst_o  out  32  registered instruction
inst_addr_o  out  XLEN  registered PC
reg_wen_o  out  1  rd write enable
reg_waddr_o  out  REG_AW  rd
csr_wen_o  out  1  CSR write enable
csr_addr_o  out  CSR_AW  CSR address
is_load_o  out  1  registered instruction is a load

Behaviour:
- Reset: all registered outputs are 0. ex_valid_o=0.
- Latency: 1 cycle. An instruction accepted at edge N appears at the outputs after edge N.
- Register addresses are combinational from inst_i: rs1/rs2 when the class uses them, else 0.
- Transfer IF->ID on if_valid_i && if_ready_o.
- Output register advance condition: adv = !ex_valid_o || ex_ready_i.
- if_ready_o = adv && !hazard && !flush_i.
- Hold: when ex_valid_o && !ex_ready_i, every output stays stable.
- Bubble: on adv with no transfer, ex_valid_o goes to 0 and the other outputs are don't-care (zeroed).
- Load-use hazard:
  - hazard = if_valid_i && ex_valid_o && is_load_o && reg_waddr_o!=0 && (incoming rs1 used && rs1==reg_waddr_o, or incoming rs2 used && rs2==reg_waddr_o).
  - Effect: one bubble is inserted. The dependent instruction issues 2 cycles after the load, given ex_ready_i=1.
- Flush: highest priority. Next edge ex_valid_o=0 regardless of ex_ready_i. No instruction is accepted that cycle.
- Simultaneous rst_i and flush_i: reset wins. Outcome is identical.
- reg_wen_o is forced to 0 when rd==0.
- Decode (sx = sign-extend to XLEN):
  - R: op1=rs1d, op2=rs2d, offset=0, wen=1.
  - I-ALU / LOAD: op1=rs1d, op2=sx(inst[31:20]), wen=1. LOAD sets is_load_o.
  - STORE: op1=rs1d, op2=rs2d, offset=sx S-imm, wen=0.
  - BRANCH: op1=rs1d, op2=rs2d, offset=sx B-imm (bit0=0), wen=0.
  - JAL: op1=PC, op2=4, offset=sx J-imm, wen=1.
  - JALR: op1=rs1d, op2=PC, offset=sx I-imm, wen=1.
  - LUI: op1=sx({inst[31:12],12'b0}), op2=0. AUIPC: same op1, op2=PC. Both wen=1.
  - CSR: csr_addr_o=inst[31:20]. op1=rs1d (reg forms) or zero-extended inst[19:15] (imm forms). wen=1. csr_wen=1, except CSRRS/CSRRC(I) with rs1/zimm==0, which give 0.
  - FENCE, unknown opcode, undefined func3: valid no-op with all enables 0 and operands 0.

Optional Feature:
ID_ILLEGAL_TRAP_EN
- Defined: adds output illegal_o (1 bit, registered, reset 0). It is 1 for unknown opcode/func3, or for R-type func7 not in {0x00, 0x20 (ADD/SUB/SRL/SRA only)}. Enables are forced to 0 for that instruction.
- Undefined: port absent; illegal encodings are a silent no-op.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with ex_ready_i=1 -> next cycle ex_valid_o=1, op2_o=5, reg_waddr_o=1, reg_wen_o=1.
- lw x2,0(x1) then add x3,x2,x2 back-to-back -> one cycle with if_ready_o=0 and ex_valid_o=0 between them; add appears 2 cycles after lw.
- ex_ready_i=0 for 3 cycles with a valid instruction held -> outputs stable, if_ready_o=0; released in cycle 4 -> next instruction advances.
- flush_i pulsed while beq held with ex_ready_i=0 -> next cycle ex_valid_o=0 and the instruction is not accepted.
- addi x0,x0,1 -> reg_wen_o=0. jal x1,-4 at PC 0x100 -> op1_o=0x100, offset_o=0xFFFFFFFC.
- XLEN=64, lui x5,0x80000 -> op1_o=0xFFFFFFFF80000000. With ID_ILLEGAL_TRAP_EN, opcode 0x7F -> illegal_o=1.
